// File: rtl/umai_pkg.sv
// rtl/umai_pkg.sv - shared UMAI flit types, command field positions and rx FSM encoding.
package umai_pkg;

  localparam int unsigned BeatFlits = 8;
  localparam int unsigned FlitW     = 72;
  localparam int unsigned PayloadW  = 64;
  localparam int unsigned BeatW     = BeatFlits * PayloadW;

  // Command field positions inside the 64-bit payload.
  localparam int unsigned CmdLenHi  = 37;
  localparam int unsigned CmdLenLo  = 32;
  localparam int unsigned CmdAddrHi = 31;
  localparam int unsigned CmdAddrLo = 0;

  typedef enum logic [1:0] {
    UMAI_FLIT_ILLEGAL = 2'b00,
    UMAI_FLIT_WCMD    = 2'b01,
    UMAI_FLIT_RCMD    = 2'b10,
    UMAI_FLIT_DATA    = 2'b11
  } umai_flit_type_e;

  typedef struct packed {
    umai_flit_type_e     ftype;
    logic                parity;
    logic [1:0]          rsvd;
    logic [2:0]          idx;
    logic [PayloadW-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_COLLECT,
    RX_HOLD_CMD,
    RX_HOLD_DATA
  } rx_state_e;

  // Even parity over the whole flit, parity bit included.
  function automatic logic flit_parity_ok(input logic [FlitW-1:0] f);
    return ~^f;
  endfunction

endpackage

// File: rtl/umai_rx_assembler_if.sv
// rtl/umai_rx_assembler_if.sv - rx flit channels plus command/beat output handshakes.
interface umai_rx_assembler_if #(
  parameter int unsigned NumChannels = 6
);
  import umai_pkg::*;

  logic [NumChannels-1:0]            i_rx_valid;
  logic [NumChannels-1:0]            o_rx_ready;
  logic [NumChannels-1:0][FlitW-1:0] i_rx_data;

  logic                              o_cmd_valid;
  logic                              i_cmd_ready;
  logic                              o_cmd_is_write;
  logic [31:0]                       o_cmd_addr;
  logic [5:0]                        o_cmd_len;

  logic                              o_data_valid;
  logic                              i_data_ready;
  logic [BeatW-1:0]                  o_data;

  logic                              o_err;

  modport slave (
    input  i_rx_valid, i_rx_data, i_cmd_ready, i_data_ready,
    output o_rx_ready, o_cmd_valid, o_cmd_is_write, o_cmd_addr, o_cmd_len,
    output o_data_valid, o_data, o_err
  );

  modport master (
    output i_rx_valid, i_rx_data, i_cmd_ready, i_data_ready,
    input  o_rx_ready, o_cmd_valid, o_cmd_is_write, o_cmd_addr, o_cmd_len,
    input  o_data_valid, o_data, o_err
  );

endinterface

// File: rtl/umai_rx_chn_ptr.sv
// rtl/umai_rx_chn_ptr.sv - round-robin AIB channel pointer over [first..last] with config sanitising.
module umai_rx_chn_ptr #(
  parameter int unsigned NumChannels = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] c_first_chn_id,
  input  logic [2:0] c_last_chn_id,
  input  logic       i_advance,
  output logic [2:0] o_ptr
);

  logic       cfg_ok;
  logic [2:0] ptr_q;
  logic [2:0] ptr_d;

  // A bad range collapses to the first channel alone, so the pointer never moves.
  assign cfg_ok = (c_last_chn_id >= c_first_chn_id) && (32'(c_last_chn_id) < NumChannels);

  always_comb begin
    ptr_d = ptr_q;
    if (i_advance) begin
      if (!cfg_ok || (ptr_q == c_last_chn_id)) begin
        ptr_d = c_first_chn_id;
      end else begin
        ptr_d = ptr_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= c_first_chn_id;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/umai_rx_assembler.sv
// rtl/umai_rx_assembler.sv - rebuilds UMAI commands and 512-bit beats from round-robin AIB flits.
// Optional even-parity check on every accepted flit when UMAI_RX_PARITY_EN is defined.
module umai_rx_assembler #(
  parameter int unsigned NumChannels = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [2:0]         c_first_chn_id,
  input  logic [2:0]         c_last_chn_id,
  umai_rx_assembler_if.slave bus
);
  import umai_pkg::*;

  rx_state_e              state_q;
  logic [2:0]             cnt_q;
  logic                   rx_en_q;
  logic                   cmd_valid_q;
  logic                   cmd_is_write_q;
  logic [31:0]            cmd_addr_q;
  logic [5:0]             cmd_len_q;
  logic                   data_valid_q;
  logic [BeatW-1:0]       data_q;
  logic                   err_q;

  logic [2:0]             ptr;
  logic [FlitW-1:0]       flit_raw;
  flit_t                  flit;
  logic                   flit_valid;
  logic                   flit_bad;
  logic                   accept;
  logic [NumChannels-1:0] rx_ready;
  logic                   unused_flit_bits;

  umai_rx_chn_ptr #(
    .NumChannels(NumChannels)
  ) u_chn_ptr (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .c_first_chn_id(c_first_chn_id),
    .c_last_chn_id (c_last_chn_id),
    .i_advance     (accept),
    .o_ptr         (ptr)
  );

  // Only the pointed-at channel is ever looked at or granted ready.
  always_comb begin
    flit_raw   = '0;
    flit_valid = 1'b0;
    rx_ready   = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (ptr == 3'(i)) begin
        flit_raw    = bus.i_rx_data[i];
        flit_valid  = bus.i_rx_valid[i];
        rx_ready[i] = rx_en_q;
      end
    end
  end

  assign flit   = flit_t'(flit_raw);
  assign accept = flit_valid && rx_en_q;

`ifdef UMAI_RX_PARITY_EN
  assign flit_bad = (flit.ftype == UMAI_FLIT_ILLEGAL) || !flit_parity_ok(flit_raw);
`else
  assign flit_bad = (flit.ftype == UMAI_FLIT_ILLEGAL);
`endif

  assign unused_flit_bits = ^{flit.parity, flit.rsvd};

  // rx_en_q mirrors "state accepts flits" but stays low through reset and the first cycle after it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= RX_IDLE;
      cnt_q          <= 3'd0;
      rx_en_q        <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_is_write_q <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_len_q      <= '0;
      data_valid_q   <= 1'b0;
      data_q         <= '0;
      err_q          <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      rx_en_q <= 1'b1;
      unique case (state_q)
        RX_IDLE: begin
          if (accept) begin
            if (flit_bad) begin
              err_q <= 1'b1;
            end else if (flit.ftype != UMAI_FLIT_DATA) begin
              cmd_is_write_q <= (flit.ftype == UMAI_FLIT_WCMD);
              cmd_addr_q     <= flit.payload[CmdAddrHi:CmdAddrLo];
              cmd_len_q      <= flit.payload[CmdLenHi:CmdLenLo];
              cmd_valid_q    <= 1'b1;
              rx_en_q        <= 1'b0;
              state_q        <= RX_HOLD_CMD;
            end else if (flit.idx == 3'd0) begin
              data_q[PayloadW-1:0] <= flit.payload;
              cnt_q                <= 3'd1;
              state_q              <= RX_COLLECT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RX_COLLECT: begin
          if (accept) begin
            if (!flit_bad && (flit.ftype == UMAI_FLIT_DATA) && (flit.idx == cnt_q)) begin
              data_q[{cnt_q, 6'd0} +: PayloadW] <= flit.payload;
              if (cnt_q == 3'(BeatFlits - 1)) begin
                cnt_q        <= 3'd0;
                data_valid_q <= 1'b1;
                rx_en_q      <= 1'b0;
                state_q      <= RX_HOLD_DATA;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end else begin
              err_q   <= 1'b1;
              cnt_q   <= 3'd0;
              state_q <= RX_IDLE;
            end
          end
        end
        RX_HOLD_CMD: begin
          rx_en_q <= 1'b0;
          if (bus.i_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            rx_en_q     <= 1'b1;
            state_q     <= RX_IDLE;
          end
        end
        RX_HOLD_DATA: begin
          rx_en_q <= 1'b0;
          if (bus.i_data_ready) begin
            data_valid_q <= 1'b0;
            rx_en_q      <= 1'b1;
            state_q      <= RX_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_rx_ready     = rx_ready;
  assign bus.o_cmd_valid    = cmd_valid_q;
  assign bus.o_cmd_is_write = cmd_is_write_q;
  assign bus.o_cmd_addr     = cmd_addr_q;
  assign bus.o_cmd_len      = cmd_len_q;
  assign bus.o_data_valid   = data_valid_q;
  assign bus.o_data         = data_q;
  assign bus.o_err          = err_q;

endmodule
